// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// The FSM encoding is fixed so that other blocks can decode it directly.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } respState_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-to-memory request/response bundle.
// The CPU drives the master side and the responder drives the slave side.
interface mem_resp_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, addr_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, addr_err
    );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word RAM with a registered read port.
// The read register changes only on read cycles, so it holds across writes.
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] wordAddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage is left uninitialised; only the read register has a reset.
    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[wordAddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[wordAddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one word request, waits WAIT_CYCLES, then
// answers with a one-cycle ready strobe (with addr_err on rejected accesses).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    mem_resp_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int OFS_W  = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    respState_t       state;
    respState_t       stateNext;
    logic [CNT_W-1:0] waitCnt;

    logic             latWe;
    logic [31:0]      latAddr;
    logic [31:0]      latWdata;

    logic             accessOk;
    logic             lastWait;
    logic             ramEn;
    logic             readyNext;
    logic             busyNext;
    logic             errNext;
    logic             readyQ;
    logic             busyQ;
    logic             errQ;
    logic [31:0]      ramQ;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.req) stateNext = WAIT;
            WAIT:    if (waitCnt == '0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The RAM is accessed on the edge entering RESP so that the registered
    // read data is already valid in the ready cycle; reset suppresses it.
    always_comb begin
        lastWait  = (state == WAIT) && (waitCnt == '0);
        ramEn     = lastWait && accessOk && !reset;
        busyNext  = (stateNext != IDLE);
        readyNext = (stateNext == RESP);
        errNext   = readyNext && !accessOk;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE:    if (bus.req) waitCnt <= CNT_LOAD;
                WAIT:    if (waitCnt != '0) waitCnt <= waitCnt - CNT_W'(1);
                default: waitCnt <= waitCnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && bus.req) begin
            latWe    <= bus.we;
            latAddr  <= bus.addr;
            latWdata <= bus.wdata;
        end
    end

    // Word aligned and no address bits above the array size.
    assign accessOk = (latAddr[OFS_W-1:0] == '0) &&
                      (latAddr[31:OFS_W+ADDR_W] == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            readyQ <= 1'b0;
            busyQ  <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            readyQ <= readyNext;
            busyQ  <= busyNext;
            errQ   <= errNext;
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .en       (ramEn),
        .we       (latWe),
        .wordAddr (latAddr[OFS_W +: ADDR_W]),
        .wdata    (latWdata),
        .rdata    (ramQ)
    );

    assign bus.ready    = readyQ;
    assign bus.busy     = busyQ;
    assign bus.addr_err = errQ;
    assign bus.rdata    = ramQ;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, handshake corner cases and
// randomized traffic checked against a word-array reference model.
module tb_mem_responder;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mem_resp_if ifM ();
    mem_resp_if ifA ();
    mem_resp_if ifB ();

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutM (
        .clock (clock), .reset (reset), .bus (ifM)
    );
    mem_responder #(.DEPTH_WORDS(4), .WAIT_CYCLES(1)) dutA (
        .clock (clock), .reset (reset), .bus (ifA)
    );
    mem_responder #(.DEPTH_WORDS(4), .WAIT_CYCLES(15)) dutB (
        .clock (clock), .reset (reset), .bus (ifB)
    );

    int nChk  = 0;
    int nPass = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        expErr;
        logic [31:0] expRd;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] mdl  [16];
    logic [31:0] expRd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE and returns the response; cyc counts
    // cycles after the accept (first cycle after the accepting edge is 1).
    task automatic doTxn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic err, output logic bsy,
                         output int cyc);
        ifM.req   = 1'b1;
        ifM.we    = w;
        ifM.addr  = a;
        ifM.wdata = d;
        @(posedge clock); #1;
        ifM.req = 1'b0;
        cyc = -1;
        rd  = '0;
        err = 1'b0;
        bsy = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (ifM.ready) begin
                cyc = k;
                rd  = ifM.rdata;
                err = ifM.addr_err;
                bsy = ifM.busy;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic        bsy;
        int          cyc;
        int          readyCnt;
        int          latA;
        int          latB;

        ifM.req = 1'b0; ifM.we = 1'b0; ifM.addr = '0; ifM.wdata = '0;
        ifA.req = 1'b0; ifA.we = 1'b0; ifA.addr = '0; ifA.wdata = '0;
        ifB.req = 1'b0; ifB.we = 1'b0; ifB.addr = '0; ifB.wdata = '0;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_ready", ifM.ready, 0);
        chk("rst_busy", ifM.busy, 0);
        chk("rst_err", ifM.addr_err, 0);
        chk("rst_rdata", ifM.rdata, 0);

        // Directed vectors; rdata holds between successful reads.
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hA5A5_A5A5};
        vecs[8] = '{1'b1, 32'h0000_03FC, 32'h7777_8888, 1'b0, 32'hA5A5_A5A5};
        vecs[9] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h7777_8888};

        for (int i = 0; i < 10; i++) begin
            doTxn(vecs[i].w, vecs[i].a, vecs[i].d, rd, err, bsy, cyc);
            chk($sformatf("vec%0d_latency", i), cyc, 3);
            chk($sformatf("vec%0d_err", i), err, vecs[i].expErr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            chk($sformatf("vec%0d_busy", i), bsy, 1);
            chk($sformatf("vec%0d_idle", i), ifM.busy, 0);
        end

        // req held high with alternating write/read: one transaction every
        // 4 cycles, ready in the third busy cycle, one idle cycle between.
        ifM.req   = 1'b1;
        ifM.we    = 1'b1;
        ifM.addr  = 32'h0000_003C;
        ifM.wdata = 32'h0F0F_0F0F;
        readyCnt  = 0;
        @(posedge clock); #1;
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("thru_ready_k%0d", k), ifM.ready, ((k % 4) == 2) ? 1 : 0);
            chk($sformatf("thru_busy_k%0d", k), ifM.busy, ((k % 4) != 3) ? 1 : 0);
            if (ifM.ready) begin
                readyCnt++;
                ifM.we = ~ifM.we;
            end
            if (k == 39) begin
                ifM.req = 1'b0;
            end else begin
                @(posedge clock); #1;
            end
        end
        chk("thru_ready_count", readyCnt, 10);
        chk("thru_rdata", ifM.rdata, 32'h0F0F_0F0F);
        @(posedge clock); #1;

        // Reset in the last wait cycle must abort the pending write.
        doTxn(1'b1, 32'h0000_0020, 32'h1111_2222, rd, err, bsy, cyc);
        chk("pre_write_latency", cyc, 3);
        ifM.req   = 1'b1;
        ifM.we    = 1'b1;
        ifM.addr  = 32'h0000_0020;
        ifM.wdata = 32'hCAFE_F00D;
        @(posedge clock); #1;
        ifM.req = 1'b0;
        chk("abort_ready_c1", ifM.ready, 0);
        chk("abort_busy_c1", ifM.busy, 1);
        @(posedge clock); #1;
        chk("abort_ready_c2", ifM.ready, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_ready_after", ifM.ready, 0);
        chk("abort_busy_after", ifM.busy, 0);
        chk("abort_rdata_after", ifM.rdata, 0);
        chk("abort_err_after", ifM.addr_err, 0);
        doTxn(1'b0, 32'h0000_0020, 32'h0, rd, err, bsy, cyc);
        chk("abort_read_latency", cyc, 3);
        chk("abort_read_err", err, 0);
        chk("abort_read_data", rd, 32'h1111_2222);
        expRd = 32'h1111_2222;

        // Other wait-state settings: ready in cycle WAIT_CYCLES+1.
        ifA.req = 1'b1; ifA.we = 1'b0; ifA.addr = '0;
        ifB.req = 1'b1; ifB.we = 1'b0; ifB.addr = '0;
        @(posedge clock); #1;
        ifA.req = 1'b0;
        ifB.req = 1'b0;
        latA = -1;
        latB = -1;
        for (int k = 1; k <= 25; k++) begin
            if (ifA.ready && latA < 0) latA = k;
            if (ifB.ready && latB < 0) latB = k;
            @(posedge clock); #1;
        end
        chk("wait1_latency", latA, 2);
        chk("wait15_latency", latB, 16);

        // Randomized traffic against a 16-word model; every model word is
        // written first so all reads have a known answer.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            doTxn(1'b1, 32'(i * 4), mdl[i], rd, err, bsy, cyc);
            chk($sformatf("init%0d_err", i), err, 0);
            chk($sformatf("init%0d_rdata", i), rd, expRd);
        end
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        eErr;
            int          kind;
            int          idx;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            w    = 1'($urandom_range(0, 1));
            d    = $urandom;
            if (kind == 0)      a = 32'(idx * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = $urandom | 32'h0000_0400;
            else                a = 32'(idx * 4);
            eErr = ((a % 4) != 0) || ((a / 4) >= 256);
            if (!eErr && w)  mdl[a / 4] = d;
            if (!eErr && !w) expRd = mdl[a / 4];
            doTxn(w, a, d, rd, err, bsy, cyc);
            chk($sformatf("rnd%0d_latency", n), cyc, 3);
            chk($sformatf("rnd%0d_err", n), err, eErr);
            chk($sformatf("rnd%0d_rdata", n), rd, expRd);
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
